dw_pack_converter: RTL and testbench

DW_PACK_CONVERTER -- requirements
Module: dw_pack_converter

---
 rtl/dw_converter_pkg.sv | 15 +
 rtl/dw_pack_converter.sv | 147 ++++++++++++++
 tb/tb_dw_pack_converter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dw_converter_pkg.sv
// rtl/dw_converter_pkg.sv - shared state encoding and width-ratio helper for the width converters
package dw_converter_pkg;

  // FILL: collecting beats into the wide word; HOLD: wide word presented downstream
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } conv_state_e;

  // Number of narrow beats carried by one wide word
  function automatic int ratio_of(input int wide_dw, input int narrow_dw);
    return wide_dw / narrow_dw;
  endfunction

endpackage

// File: rtl/dw_pack_converter.sv
// rtl/dw_pack_converter.sv - narrow-to-wide beat packer; define DW_PACK_CONVERTER_LAST_EN for last_i early flush
module dw_pack_converter
  import dw_converter_pkg::*;
#(
  parameter int INPUT_DW  = 64,
  parameter int OUTPUT_DW = 512,
  localparam int RATIO    = ratio_of(OUTPUT_DW, INPUT_DW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INPUT_DW-1:0]  data_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  output logic                 ready_o,
  output logic [OUTPUT_DW-1:0] data_o,
  output logic [RATIO-1:0]     keep_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

  if (((OUTPUT_DW % INPUT_DW) != 0) || (RATIO < 2)) begin : g_bad_ratio
    $error("dw_pack_converter: OUTPUT_DW must be a multiple (>=2) of INPUT_DW");
  end

  conv_state_e            state_q;
  conv_state_e            state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          wr_slot;
  logic [OUTPUT_DW-1:0]   data_q;
  logic                   beat_acc;
  logic                   word_drain;
  logic                   close_word;
  logic                   beat_last;

`ifdef DW_PACK_CONVERTER_LAST_EN
  assign beat_last = last_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign beat_last   = 1'b0;
`endif

  // While a word is held, upstream may only advance in the same cycle the word drains
  assign ready_o    = rst_i ? 1'b0 : ((state_q == FILL) ? 1'b1 : ready_i);
  assign beat_acc   = valid_i & ready_o;
  assign word_drain = (state_q == HOLD) & ready_i;
  // A beat accepted in HOLD always starts a fresh word at slot 0
  assign wr_slot    = (state_q == HOLD) ? '0 : cnt_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: close on the last slot or on a flagged beat, release on drain
  always_comb begin
    state_d    = state_q;
    close_word = 1'b0;
    case (state_q)
      FILL: begin
        if (beat_acc && ((cnt_q == LAST_SLOT) || beat_last)) begin
          close_word = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (beat_acc && beat_last) begin
            close_word = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Word buffer and slot counter; draining clears the buffer so unwritten slots read zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (word_drain) begin
        data_q <= '0;
      end
      if (beat_acc) begin
        for (int k = 0; k < RATIO; k++) begin
          if (wr_slot == CW'(k)) begin
            data_q[k*INPUT_DW +: INPUT_DW] <= data_i;
          end
        end
      end
      if (close_word) begin
        cnt_q <= '0;
      end else if (beat_acc) begin
        cnt_q <= wr_slot + 1'b1;
      end
    end
  end

  assign valid_o = (state_q == HOLD);
  assign data_o  = data_q;

`ifdef DW_PACK_CONVERTER_LAST_EN
  logic [RATIO-1:0] keep_q;
  logic             last_q;

  // Per-slot written mask and transfer-end flag of the word being built
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (word_drain) begin
        keep_q <= '0;
        last_q <= 1'b0;
      end
      if (beat_acc) begin
        for (int k = 0; k < RATIO; k++) begin
          if (wr_slot == CW'(k)) begin
            keep_q[k] <= 1'b1;
          end
        end
        last_q <= last_i;
      end
    end
  end

  assign keep_o = valid_o ? keep_q : '0;
  assign last_o = valid_o & last_q;
`else
  assign keep_o = {RATIO{valid_o}};
  assign last_o = 1'b0;
`endif

endmodule

// File: tb/tb_dw_pack_converter.sv
// tb/tb_dw_pack_converter.sv - self-checking bench for dw_pack_converter (honours DW_PACK_CONVERTER_LAST_EN)
module tb_dw_pack_converter;

  localparam int IDW = 64;
  localparam int ODW = 512;
  localparam int R   = 8;
`ifdef DW_PACK_CONVERTER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] data_i;
  logic           valid_i;
  logic           last_i;
  logic           ready_o;
  logic [ODW-1:0] data_o;
  logic [R-1:0]   keep_o;
  logic           last_o;
  logic           valid_o;
  logic           ready_i;

  always #5 clk = ~clk;

  dw_pack_converter #(.INPUT_DW(IDW), .OUTPUT_DW(ODW)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .keep_o (keep_o),
    .last_o (last_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  typedef struct {
    logic [ODW-1:0] data;
    logic [R-1:0]   keep;
    logic           last;
  } word_t;

  word_t          exp_q[$];
  word_t          obs_q[$];
  logic [ODW-1:0] m_data;
  logic [R-1:0]   m_keep;
  int             m_n;
  bit             m_hold;
  int             errors = 0;
  int             checks = 0;

  task automatic model_clear();
    m_data = '0; m_keep = '0; m_n = 0; m_hold = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  // One clock: entered at posedge+1, samples mid-cycle, returns at next posedge+1
  task automatic step();
    word_t w;
    bit    exp_rdy;
    #2;
    exp_rdy = !m_hold || ready_i;
    if (valid_o && ready_i) begin
      w.data = data_o; w.keep = keep_o; w.last = last_o;
      obs_q.push_back(w);
    end
    if (m_hold && ready_i) m_hold = 1'b0;
    if (valid_i && exp_rdy) begin
      m_data[m_n*IDW +: IDW] = data_i;
      m_keep[m_n] = 1'b1;
      m_n++;
      if (m_n == R || (LAST_EN && last_i)) begin
        w.data = m_data;
        w.keep = LAST_EN ? m_keep : {R{1'b1}};
        w.last = LAST_EN && last_i;
        exp_q.push_back(w);
        m_data = '0; m_keep = '0; m_n = 0; m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
    checks++; if (keep_o !== '0) begin errors++; $display("FAIL reset_keep got=%h exp=0", keep_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", last_o); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", ready_o); end
  endtask

  task automatic test_single_word();
    word_t wo, we;
    ready_i = 1'b1; valid_i = 1'b1; last_i = 1'b0;
    for (int k = 0; k < R; k++) begin
      data_i = IDW'(k);
      if (k == R - 1) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_fill_valid got=%0b exp=0", valid_o); end
      end
      step();
    end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got=%0b exp=1", valid_o); end
    checks++; if (keep_o !== 8'hFF) begin errors++; $display("FAIL single_keep got=%h exp=ff", keep_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL single_last got=%0b exp=0", last_o); end
    drain(1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      for (int k = 0; k < R; k++) begin
        checks++; if (wo.data[k*IDW +: IDW] !== IDW'(k)) begin errors++; $display("FAIL single_slot%0d got=%h exp=%h", k, wo.data[k*IDW +: IDW], k); end
      end
      checks++; if (wo.data !== we.data || wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL single_word got=%h/%h/%0b exp=%h/%h/%0b", wo.data, wo.keep, wo.last, we.data, we.keep, we.last); end
    end
  endtask

  task automatic test_back_to_back();
    word_t wo, we;
    ready_i = 1'b1; valid_i = 1'b1; last_i = 1'b0;
    for (int i = 0; i < 2*R; i++) begin
      data_i = {$urandom, $urandom};
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=1", i, ready_o); end
      if (i == R) begin
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first_word got=%0b exp=1", valid_o); end
      end
      step();
    end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_second_word got=%0b exp=1", valid_o); end
    drain(1);
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      checks++; if (wo.data !== we.data || wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL b2b_word got=%h/%h/%0b exp=%h/%h/%0b", wo.data, wo.keep, wo.last, we.data, we.keep, we.last); end
    end
  endtask

  task automatic test_partial_last();
    word_t wo, we;
    ready_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_i = {$urandom, $urandom};
      last_i = (k == 2);
      step();
    end
    last_i = 1'b0;
`ifdef DW_PACK_CONVERTER_LAST_EN
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL partial_valid got=%0b exp=1", valid_o); end
    checks++; if (keep_o !== 8'h07) begin errors++; $display("FAIL partial_keep got=%h exp=07", keep_o); end
    checks++; if (last_o !== 1'b1) begin errors++; $display("FAIL partial_last got=%0b exp=1", last_o); end
    checks++; if (data_o[ODW-1:3*IDW] !== '0) begin errors++; $display("FAIL partial_upper got=%h exp=0", data_o[ODW-1:3*IDW]); end
`else
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL partial_no_flush got=%0b exp=0", valid_o); end
    for (int k = 0; k < 5; k++) begin
      data_i = {$urandom, $urandom};
      if (k == 4) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL partial_early got=%0b exp=0", valid_o); end
      end
      step();
    end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL partial_full got=%0b exp=1", valid_o); end
    checks++; if (keep_o !== 8'hFF) begin errors++; $display("FAIL partial_keep got=%h exp=ff", keep_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL partial_last got=%0b exp=0", last_o); end
`endif
    drain(1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL partial_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      checks++; if (wo.data !== we.data || wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL partial_word got=%h/%h/%0b exp=%h/%h/%0b", wo.data, wo.keep, wo.last, we.data, we.keep, we.last); end
    end
  endtask

  task automatic test_backpressure();
    word_t          wo, we;
    logic [ODW-1:0] held;
    logic [IDW-1:0] x;
    ready_i = 1'b1; valid_i = 1'b1; last_i = 1'b0;
    for (int k = 0; k < R; k++) begin
      data_i = {$urandom, $urandom};
      step();
    end
    held = exp_q[0].data;
    ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      data_i = {$urandom, $urandom};
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", c, ready_o); end
      checks++; if (valid_o !== 1'b1 || data_o !== held) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0b/%h exp=1/%h", c, valid_o, data_o, held); end
      step();
    end
    x = {$urandom, $urandom};
    data_i = x; ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", ready_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_refill_valid got=%0b exp=0", valid_o); end
    checks++; if (data_o[IDW-1:0] !== x || data_o[ODW-1:IDW] !== '0) begin errors++; $display("FAIL bp_slot0 got=%h exp=%h", data_o, x); end
    for (int k = 1; k < R; k++) begin
      data_i = {$urandom, $urandom};
      step();
    end
    drain(1);
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      checks++; if (wo.data !== we.data || wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL bp_word got=%h/%h/%0b exp=%h/%h/%0b", wo.data, wo.keep, wo.last, we.data, we.keep, we.last); end
    end
  endtask

  task automatic test_reset_midword();
    word_t wo, we;
    ready_i = 1'b1; valid_i = 1'b1; last_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_i = {$urandom, $urandom};
      step();
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL midrst_hs got=%0b/%0b exp=0/0", ready_o, valid_o); end
    checks++; if (data_o !== '0 || keep_o !== '0 || last_o !== 1'b0) begin errors++; $display("FAIL midrst_out got=%h/%h/%0b exp=0", data_o, keep_o, last_o); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_clear();
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_release got=%0b exp=1", ready_o); end
    valid_i = 1'b1;
    for (int k = 0; k < R; k++) begin
      data_i = IDW'(8'h10 + k);
      step();
    end
    drain(1);
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      for (int k = 0; k < R; k++) begin
        checks++; if (wo.data[k*IDW +: IDW] !== IDW'(8'h10 + k)) begin errors++; $display("FAIL midrst_slot%0d got=%h exp=%h", k, wo.data[k*IDW +: IDW], 8'h10 + k); end
      end
      checks++; if (wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL midrst_word got=%h/%0b exp=%h/%0b", wo.keep, wo.last, we.keep, we.last); end
    end
  endtask

  task automatic test_random();
    word_t          wo, we;
    logic           p_hold;
    logic [ODW-1:0] p_data;
    logic [R-1:0]   p_keep;
    logic           p_last;
    p_hold = 1'b0; p_data = '0; p_keep = '0; p_last = 1'b0;
    for (int c = 0; c < 400; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      last_i  = ($urandom_range(0, 7) == 0);
      data_i  = {$urandom, $urandom};
      #1;
      checks++; if (ready_o !== (!m_hold || ready_i)) begin errors++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, ready_o, !m_hold || ready_i); end
      if (p_hold) begin
        checks++; if (valid_o !== 1'b1 || data_o !== p_data || keep_o !== p_keep || last_o !== p_last) begin errors++; $display("FAIL rand_stable cyc=%0d got=%0b/%h/%0b exp=1/%h/%0b", c, valid_o, keep_o, last_o, p_keep, p_last); end
      end
      p_hold = valid_o && !ready_i;
      p_data = data_o; p_keep = keep_o; p_last = last_o;
      step();
    end
    drain(3);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wo = obs_q.pop_front(); we = exp_q.pop_front();
      checks++; if (wo.data !== we.data || wo.keep !== we.keep || wo.last !== we.last) begin errors++; $display("FAIL rand_word got=%h/%h/%0b exp=%h/%h/%0b", wo.data, wo.keep, wo.last, we.data, we.keep, we.last); end
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; last_i = 1'b0; data_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_last();
    test_backpressure();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
